// File: rtl/rr_grant_arbiter.sv
// Round-robin arbiter for 2**n requesters with a hold-time limit.
// Winner is emitted as an index + valid pair and as a one-hot grant.
module rr_grant_arbiter #(
  parameter int n        = 2,
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [2**n-1:0]   req,
  input  logic              done,
  output logic [n-1:0]      grantIdx,
  output logic              grantValid,
  output logic [2**n-1:0]   grant,
  output logic              timeout
);

  // state | meaning
  // IDLE  | no owner; arbitrate among req starting at ptr
  // BUSY  | grant held by grant_idx_q until done, owner drop or hold limit
  typedef enum logic {IDLE, BUSY} state_t;

  localparam int N           = 2**n;
  localparam bit HOLD_EN     = (MAX_HOLD != 0);
  localparam int HOLD_LAST_I = (MAX_HOLD > 0) ? MAX_HOLD - 1 : 0;
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_LAST_I);

  state_t           state_q,       state_d;
  logic [n-1:0]     ptr_q,         ptr_d;
  logic [CNT_W-1:0] hold_cnt_q,    hold_cnt_d;
  logic [n-1:0]     grant_idx_q,   grant_idx_d;
  logic             grant_valid_q, grant_valid_d;
  logic [N-1:0]     grant_q,       grant_d;
  logic             timeout_q,     timeout_d;

  logic             pick_found;
  logic [n-1:0]     pick_idx;
  logic [n-1:0]     cand;
  logic             owner_req;
  logic             hold_hit;
  logic             release_now;

  // First set request at or above ptr, wrapping through the natural n-bit overflow.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int i = 0; i < N; i++) begin
      cand = ptr_q + n'(i);
      if (!pick_found && req[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  always_comb begin
    owner_req   = req[grant_idx_q];
    hold_hit    = HOLD_EN && (hold_cnt_q == HOLD_LAST);
    release_now = done || !owner_req || hold_hit;
  end

  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    hold_cnt_d    = hold_cnt_q;
    grant_idx_d   = grant_idx_q;
    grant_valid_d = grant_valid_q;
    grant_d       = grant_q;
    timeout_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          grant_idx_d        = pick_idx;
          grant_valid_d      = 1'b1;
          grant_d            = '0;
          grant_d[pick_idx]  = 1'b1;
          hold_cnt_d         = '0;
          state_d            = BUSY;
        end
      end
      BUSY: begin
        if (release_now) begin
          grant_valid_d = 1'b0;
          grant_d       = '0;
          ptr_d         = grant_idx_q + n'(1);
          state_d       = IDLE;
          // Revocation is only flagged when the limit alone ended the grant.
          timeout_d     = hold_hit && !done && owner_req;
        end else if (hold_cnt_q != {CNT_W{1'b1}}) begin
          hold_cnt_d = hold_cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      ptr_q         <= '0;
      hold_cnt_q    <= '0;
      grant_idx_q   <= '0;
      grant_valid_q <= 1'b0;
      grant_q       <= '0;
      timeout_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      hold_cnt_q    <= hold_cnt_d;
      grant_idx_q   <= grant_idx_d;
      grant_valid_q <= grant_valid_d;
      grant_q       <= grant_d;
      timeout_q     <= timeout_d;
    end
  end

  assign grantIdx   = grant_idx_q;
  assign grantValid = grant_valid_q;
  assign grant      = grant_q;
  assign timeout    = timeout_q;

endmodule

// File: tb/tb_rr_grant_arbiter.sv
// Directed bench for rr_grant_arbiter: expected outputs are queued with each
// stimulus step and compared once the DUT has clocked; grant invariants checked every cycle.
module tb_rr_grant_arbiter;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic       done;
  logic [1:0] grantIdx;
  logic       grantValid;
  logic [3:0] grant;
  logic       timeout;

  int checks = 0;
  int errors = 0;
  bit inv_on = 1'b0;

  typedef struct {
    logic [3:0] g;
    logic [1:0] i;
    logic       v;
    logic       t;
    string      tag;
  } exp_t;

  exp_t sb[$];

  rr_grant_arbiter #(.n(2), .MAX_HOLD(8), .CNT_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .done       (done),
    .grantIdx   (grantIdx),
    .grantValid (grantValid),
    .grant      (grant),
    .timeout    (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h required=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [3:0] eg, input logic [1:0] ei, input logic ev,
                      input logic et, input string tag);
    exp_t e;
    e.g = eg; e.i = ei; e.v = ev; e.t = et; e.tag = tag;
    sb.push_back(e);
  endtask

  task automatic sample();
    exp_t e;
    checks++;
    assert (sb.size() > 0) else begin
      errors++;
      $error("FAIL scoreboard_empty: observed=0 required=1");
    end
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk({e.tag, "_grant"}, 32'(grant), 32'(e.g));
      chk({e.tag, "_idx"},   32'(grantIdx), 32'(e.i));
      chk({e.tag, "_valid"}, 32'(grantValid), 32'(e.v));
      chk({e.tag, "_timeout"}, 32'(timeout), 32'(e.t));
    end
  endtask

  // One clock: drive inputs, queue what the outputs must be after the edge, then compare.
  task automatic cyc(input logic [3:0] r, input logic d, input logic [3:0] eg,
                     input logic [1:0] ei, input logic ev, input logic et, input string tag);
    req  = r;
    done = d;
    push(eg, ei, ev, et, tag);
    @(posedge clk);
    #1;
    sample();
  endtask

  always @(negedge clk) begin
    if (inv_on) begin
      checks++;
      assert (($countones(grant) <= 1) && ((grant == 4'b0000) == !grantValid)
              && (grant[grantIdx] == grantValid)) else begin
        errors++;
        $error("FAIL invariant: observed grant=%b idx=%0d valid=%b required consistent decode",
               grant, grantIdx, grantValid);
      end
    end
  end

  initial begin
    rst_n = 1'b1;
    req   = 4'b1111;
    done  = 1'b0;
    #2 rst_n = 1'b0;
    push(4'b0000, 2'd0, 1'b0, 1'b0, "reset");
    #2 sample();
    inv_on = 1'b1;
    @(posedge clk);
    #1 rst_n = 1'b1;

    cyc(4'b1111, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0, "rst_first");
    cyc(4'b1111, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0, "fair_rel0");
    cyc(4'b1111, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0, "fair_g1");
    cyc(4'b1111, 1'b1, 4'b0000, 2'd1, 1'b0, 1'b0, "fair_rel1");
    cyc(4'b1111, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0, "fair_g2");
    cyc(4'b1111, 1'b1, 4'b0000, 2'd2, 1'b0, 1'b0, "fair_rel2");
    cyc(4'b1111, 1'b0, 4'b1000, 2'd3, 1'b1, 1'b0, "fair_g3");
    cyc(4'b1111, 1'b1, 4'b0000, 2'd3, 1'b0, 1'b0, "fair_rel3");
    cyc(4'b1111, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0, "fair_g0_again");
    cyc(4'b1111, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0, "fair_rel0_again");

    cyc(4'b0100, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0, "single_g2");
    cyc(4'b0100, 1'b1, 4'b0000, 2'd2, 1'b0, 1'b0, "single_done");
    cyc(4'b0100, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0, "single_wrap_g2");
    cyc(4'b0100, 1'b1, 4'b0000, 2'd2, 1'b0, 1'b0, "single_done2");
    cyc(4'b0000, 1'b1, 4'b0000, 2'd2, 1'b0, 1'b0, "idle_done_ignored");

    cyc(4'b0001, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0, "to_grant");
    for (int k = 0; k < 7; k++)
      cyc(4'b0001, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0, "to_hold");
    cyc(4'b0001, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b1, "to_fire");
    cyc(4'b0001, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0, "to_regrant");

    cyc(4'b0011, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0, "drop_setup_rel");
    cyc(4'b0011, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0, "drop_g1");
    cyc(4'b0001, 1'b0, 4'b0000, 2'd1, 1'b0, 1'b0, "drop_owner");
    cyc(4'b0001, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0, "drop_wrap_g0");
    cyc(4'b1001, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0, "nonowner_change");
    for (int k = 0; k < 6; k++)
      cyc(4'b0001, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0, "tie_hold");
    cyc(4'b0001, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0, "tie_done_timeout");

    cyc(4'b1000, 1'b0, 4'b1000, 2'd3, 1'b1, 1'b0, "mid_g3");
    #3 rst_n = 1'b0;
    push(4'b0000, 2'd0, 1'b0, 1'b0, "mid_reset");
    #1 sample();
    #2 rst_n = 1'b1;
    cyc(4'b1000, 1'b0, 4'b1000, 2'd3, 1'b1, 1'b0, "post_reset_g3");
    cyc(4'b1001, 1'b1, 4'b0000, 2'd3, 1'b0, 1'b0, "post_reset_rel");
    cyc(4'b1001, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0, "post_reset_wrap");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
